// File: rtl/wait_ctrl.sv
// Wait-state controller for the 65C816 bus: stretches slow-device accesses by
// holding RDY low for a per-device programmable count of PHI2 cycles.
module wait_ctrl #(
  parameter logic [1:0] RESET_WAIT = 2'd3,
  parameter logic       RESET_EN   = 1'b1
) (
  input  logic       PHI2,
  input  logic       RESET,
  input  logic       VDA,
  input  logic       VPA,
  input  logic       RWB,
  input  logic       A0,
  input  logic [7:0] DB,
  input  logic       CFGSELB,
  input  logic       ROMCSB,
  input  logic       IO1SELB,
  input  logic       IO2SELB,
  input  logic       IO3SELB,
  input  logic       IO4SELB,
  output logic       RDY,
  output logic [7:0] DOUT,
  output logic       DOE
);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  logic [7:0] cfg0_q, cfg0_d;
  logic [1:0] io4_q, io4_d;
  logic       en_q, en_d;

  state_t     state_q;
  logic [1:0] cnt_q;
  logic       rdy_q;

  logic       cfg_wr;
  logic       acc_vld;
  logic [1:0] n_raw;
  logic [1:0] n_eff;

  function automatic logic [1:0] max2(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [1:0] field(input logic sel_n, input logic [1:0] w);
    return sel_n ? 2'd0 : w;
  endfunction

  assign cfg_wr = !CFGSELB && !RWB;

  always_comb begin
    cfg0_d = cfg0_q;
    io4_d  = io4_q;
    en_d   = en_q;
    if (cfg_wr) begin
      if (A0) begin
        io4_d = DB[1:0];
        en_d  = DB[7];
      end else begin
        cfg0_d = DB;
      end
    end
  end

  always_ff @(posedge PHI2 or posedge RESET) begin
    if (RESET) begin
      cfg0_q <= {4{RESET_WAIT}};
      io4_q  <= RESET_WAIT;
      en_q   <= RESET_EN;
    end else begin
      cfg0_q <= cfg0_d;
      io4_q  <= io4_d;
      en_q   <= en_d;
    end
  end

  // Several selects low at once: the slowest asserted device wins.
  // A config-register access is never itself stretched.
  always_comb begin
    acc_vld = (VDA || VPA) && CFGSELB;
    n_raw   = max2(max2(max2(field(ROMCSB,  cfg0_q[1:0]), field(IO1SELB, cfg0_q[3:2])),
                        max2(field(IO2SELB, cfg0_q[5:4]), field(IO3SELB, cfg0_q[7:6]))),
                   field(IO4SELB, io4_q));
    n_eff   = (en_q && acc_vld) ? n_raw : 2'd0;
  end

  // Selects are not re-sampled in WAIT; the CPU holds them while stalled.
  always_ff @(posedge PHI2 or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= 2'd0;
      rdy_q   <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (n_eff != 2'd0) begin
            rdy_q   <= 1'b0;
            cnt_q   <= n_eff - 2'd1;
            state_q <= ST_WAIT;
          end else begin
            rdy_q   <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (cnt_q == 2'd0) begin
            rdy_q   <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            cnt_q   <= cnt_q - 2'd1;
          end
        end
      endcase
    end
  end

  assign RDY  = rdy_q;
  assign DOUT = A0 ? {en_q, 5'b0, io4_q} : cfg0_q;
  assign DOE  = !CFGSELB && RWB && PHI2;

endmodule

// File: tb/tb_wait_ctrl.sv
// Bench for wait_ctrl: directed scenarios plus random traffic, checked against
// a transaction-level model of the config registers and stall lengths.
module tb_wait_ctrl;

  logic       PHI2, RESET, VDA, VPA, RWB, A0, CFGSELB;
  logic       ROMCSB, IO1SELB, IO2SELB, IO3SELB, IO4SELB;
  logic [7:0] DB;
  logic       RDY, DOE;
  logic [7:0] DOUT;

  wait_ctrl #(.RESET_WAIT(2'd3), .RESET_EN(1'b1)) dut (
    .PHI2(PHI2), .RESET(RESET), .VDA(VDA), .VPA(VPA), .RWB(RWB), .A0(A0),
    .DB(DB), .CFGSELB(CFGSELB), .ROMCSB(ROMCSB), .IO1SELB(IO1SELB),
    .IO2SELB(IO2SELB), .IO3SELB(IO3SELB), .IO4SELB(IO4SELB),
    .RDY(RDY), .DOUT(DOUT), .DOE(DOE)
  );

  initial PHI2 = 1'b0;
  always #5 PHI2 = ~PHI2;

  int n_chk  = 0;
  int n_pass = 0;

  // Model: wait count per device (0=ROM, 1..4=IO1..IO4) and global enable.
  logic [1:0] m_w [5];
  logic       m_en;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic void m_reset();
    for (int i = 0; i < 5; i++) m_w[i] = 2'd3;
    m_en = 1'b1;
  endfunction

  function automatic void m_write(input logic a0, input logic [7:0] db);
    if (a0) begin
      m_w[4] = db[1:0];
      m_en   = db[7];
    end else begin
      for (int i = 0; i < 4; i++) m_w[i] = 2'((db >> (2 * i)) & 8'h03);
    end
  endfunction

  function automatic logic [7:0] m_cfg(input logic a0);
    if (a0) return {m_en, 5'b0, m_w[4]};
    return {m_w[3], m_w[2], m_w[1], m_w[0]};
  endfunction

  function automatic int m_stall(input logic [4:0] mask, input logic vda, input logic vpa);
    int n = 0;
    if (!m_en || !(vda || vpa)) return 0;
    for (int i = 0; i < 5; i++)
      if (mask[i] && int'(m_w[i]) > n) n = int'(m_w[i]);
    return n;
  endfunction

  task automatic drive_sel(input logic [4:0] mask);
    ROMCSB  = ~mask[0];
    IO1SELB = ~mask[1];
    IO2SELB = ~mask[2];
    IO3SELB = ~mask[3];
    IO4SELB = ~mask[4];
  endtask

  // All tasks start and end just after a falling edge of PHI2.
  task automatic cfg_write(input logic a0, input logic [7:0] db);
    CFGSELB = 1'b0; RWB = 1'b0; A0 = a0; DB = db;
    @(negedge PHI2);
    CFGSELB = 1'b1; RWB = 1'b1;
    m_write(a0, db);
  endtask

  task automatic cfg_read(input string tag, input logic a0);
    CFGSELB = 1'b0; RWB = 1'b1; A0 = a0;
    #1;
    chk({tag, "_dout_lo"}, DOUT, m_cfg(a0));
    chk({tag, "_doe_lo"}, {7'b0, DOE}, 8'h00);
    @(posedge PHI2); #1;
    chk({tag, "_dout_hi"}, DOUT, m_cfg(a0));
    chk({tag, "_doe_hi"}, {7'b0, DOE}, 8'h01);
    @(negedge PHI2);
    CFGSELB = 1'b1;
  endtask

  task automatic access(input string tag, input logic [4:0] mask, input logic vda,
                        input logic vpa, input logic do_wr, input logic wa0,
                        input logic [7:0] wdb);
    int  exp, cnt;
    bit  done;
    exp  = m_stall(mask, vda, vpa);
    cnt  = 0;
    done = 0;
    drive_sel(mask); VDA = vda; VPA = vpa;
    for (int c = 0; c < 8 && !done; c++) begin
      @(negedge PHI2);
      if (RDY === 1'b0) begin
        cnt++;
        if (do_wr && cnt == 1) begin
          CFGSELB = 1'b0; RWB = 1'b0; A0 = wa0; DB = wdb;
        end else if (do_wr && cnt == 2) begin
          CFGSELB = 1'b1; RWB = 1'b1;
        end
      end else begin
        done = 1;
      end
    end
    drive_sel(5'b0); VDA = 1'b0; VPA = 1'b0; CFGSELB = 1'b1; RWB = 1'b1;
    if (do_wr) m_write(wa0, wdb);
    chk(tag, 8'(cnt), 8'(exp));
  endtask

  initial begin
    int         n;
    logic [4:0] rmask;
    logic [7:0] rdb;
    RESET = 1'b1; VDA = 1'b0; VPA = 1'b0; RWB = 1'b1; A0 = 1'b0; DB = 8'h00;
    CFGSELB = 1'b1;
    drive_sel(5'b0);
    m_reset();
    repeat (2) @(negedge PHI2);
    chk("rst_rdy", {7'b0, RDY}, 8'h01);
    RESET = 1'b0;
    @(negedge PHI2);

    cfg_read("rst_cfg0", 1'b0);
    chk("rst_cfg0_lit", m_cfg(1'b0), 8'hFF);
    cfg_read("rst_cfg1", 1'b1);
    chk("rst_cfg1_lit", m_cfg(1'b1), 8'h83);
    access("rst_rom", 5'b00001, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);

    cfg_write(1'b0, 8'b00_01_10_11);
    cfg_write(1'b1, 8'h80);
    access("dev_rom", 5'b00001, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    access("dev_io1", 5'b00010, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    access("dev_io2", 5'b00100, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    access("dev_io3", 5'b01000, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    access("dev_io4", 5'b10000, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);

    access("noqual_io1", 5'b00010, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    cfg_write(1'b1, 8'h03);
    access("dis_io4", 5'b10000, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    cfg_read("dis_cfg1", 1'b1);
    chk("dis_cfg1_lit", m_cfg(1'b1), 8'h03);

    // Back-to-back ROM accesses with the select held low throughout.
    cfg_write(1'b1, 8'h80);
    cfg_write(1'b0, 8'b00_01_10_10);
    n = m_stall(5'b00001, 1'b0, 1'b1);
    drive_sel(5'b00001); VPA = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge PHI2);
      chk($sformatf("b2b_%0d", k), {7'b0, RDY}, (k % (n + 1) == n) ? 8'h01 : 8'h00);
    end
    drive_sel(5'b0); VPA = 1'b0;

    // Two selects together, with IO1 reprogrammed mid-stall.
    access("multi_wr", 5'b00110, 1'b1, 1'b0, 1'b1, 1'b0, 8'b00_01_11_10);
    access("io1_new", 5'b00010, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    cfg_read("new_cfg0", 1'b0);

    // Reset between edges while stalled.
    drive_sel(5'b00010); VDA = 1'b1;
    @(negedge PHI2);
    chk("mid_stall_rdy", {7'b0, RDY}, 8'h00);
    #2 RESET = 1'b1;
    #1 chk("async_rst_rdy", {7'b0, RDY}, 8'h01);
    drive_sel(5'b0); VDA = 1'b0;
    @(negedge PHI2);
    RESET = 1'b0;
    m_reset();
    @(negedge PHI2);
    chk("post_rst_rdy", {7'b0, RDY}, 8'h01);
    cfg_read("post_rst_cfg0", 1'b0);
    cfg_read("post_rst_cfg1", 1'b1);
    access("post_rst_rom", 5'b00001, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);

    for (int it = 0; it < 60; it++) begin
      n = int'($urandom_range(0, 9));
      rdb = 8'($urandom);
      rmask = 5'($urandom);
      if (n < 3) cfg_write(rdb[6], rdb ^ 8'($urandom));
      else if (n < 5) cfg_read($sformatf("rnd_rd_%0d", it), rdb[0]);
      else access($sformatf("rnd_acc_%0d", it), rmask, rdb[1], rdb[2], 1'b0, 1'b0, 8'h00);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
